// File: rtl/intr_stack_if.sv
// ============================================================================
//  Module      : intr_stack_if
//  Description : CPU <-> interrupt/return-stack controller signal bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface intr_stack_if #(
    parameter int N_IRQ = 4,
    parameter int AW    = 10
);
    // Requests toward the controller
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] irq_mask;
    logic             ei;
    logic             di;
    logic             instr_end;
    logic [AW-1:0]    next_pc;
    logic             cpu_push;
    logic [AW-1:0]    cpu_din;
    logic             cpu_pop;
    logic             reti;

    // Responses from the controller
    logic             stk_push;
    logic             stk_pop;
    logic             stk_intr;
    logic [AW-1:0]    stk_din;
    logic             pc_load;
    logic [AW-1:0]    vector;
    logic             cpu_stall;
    logic [N_IRQ-1:0] irq_ack;
    logic             gie;
    logic [4:0]       depth;
    logic             stk_err;

    modport master (
        output irq, irq_mask, ei, di, instr_end, next_pc,
               cpu_push, cpu_din, cpu_pop, reti,
        input  stk_push, stk_pop, stk_intr, stk_din, pc_load, vector,
               cpu_stall, irq_ack, gie, depth, stk_err
    );

    modport slave (
        input  irq, irq_mask, ei, di, instr_end, next_pc,
               cpu_push, cpu_din, cpu_pop, reti,
        output stk_push, stk_pop, stk_intr, stk_din, pc_load, vector,
               cpu_stall, irq_ack, gie, depth, stk_err
    );
endinterface

`default_nettype wire

// File: rtl/intr_stack_ctrl.sv
// ============================================================================
//  Module      : intr_stack_ctrl
//  Description : Edge-triggered priority interrupt controller sharing the
//                CPU return stack, with per-level call/interrupt frame tags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module intr_stack_ctrl #(
    parameter int N_IRQ      = 4,
    parameter int AW         = 10,
    parameter int DEPTH      = 16,
    parameter int VEC_BASE   = 'h3E0,
    parameter int VEC_STRIDE = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    intr_stack_if.slave   bus
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [4:0]    c_depth_max  = 5'(DEPTH);
    localparam logic [AW-1:0] c_vec_base   = AW'(VEC_BASE);
    localparam logic [AW-1:0] c_vec_stride = AW'(VEC_STRIDE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PUSH   = 2'd1,
        ST_VECTOR = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_pending;
    logic [DEPTH-1:0] r_frame;
    logic [4:0]       r_depth;
    logic             r_gie;
    logic             r_err;
    logic [AW-1:0]    r_ret_pc;
    logic [IW-1:0]    r_idx;
    logic             r_int_push;
    logic             r_pc_load;
    logic             r_stall;
    logic [AW-1:0]    r_vector;
    logic [N_IRQ-1:0] r_ack;

    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_req;
    logic [N_IRQ-1:0] w_clr;
    logic [IW-1:0]    w_idx;
    logic [DW-1:0]    w_top_idx;
    logic             w_idle;
    logic             w_full;
    logic             w_empty;
    logic             w_cpu_push_ok;
    logic             w_cpu_pop_ok;
    logic             w_push_err;
    logic             w_pop_err;
    logic             w_take;
    logic             w_stk_intr;
    logic             w_reti_ok;

    assign w_edge    = bus.irq & ~r_irq_q;
    assign w_req     = r_pending & bus.irq_mask;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_full    = (r_depth == c_depth_max);
    assign w_empty   = (r_depth == 5'd0);
    assign w_top_idx = DW'(r_depth - 5'd1);
    assign w_clr     = (r_state == ST_VECTOR) ? r_ack : '0;

    // A simultaneous CPU push and pop is resolved in favour of the push.
    assign w_cpu_push_ok = w_idle & bus.cpu_push & ~w_full;
    assign w_cpu_pop_ok  = w_idle & bus.cpu_pop & ~bus.cpu_push & ~w_empty;
    assign w_push_err    = w_idle & bus.cpu_push & w_full;
    assign w_pop_err     = w_idle & bus.cpu_pop & ~bus.cpu_push & w_empty;

    assign w_stk_intr = ~w_empty & r_frame[w_top_idx];
    assign w_reti_ok  = w_cpu_pop_ok & bus.reti & w_stk_intr;

    assign w_take = w_idle & bus.instr_end & r_gie & (|w_req)
                  & ~bus.cpu_push & ~bus.cpu_pop & ~w_full;

    // Lowest-numbered requesting source wins.
    always_comb begin
        w_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_irq_q    <= '0;
            r_pending  <= '0;
            r_frame    <= '0;
            r_depth    <= '0;
            r_gie      <= 1'b0;
            r_err      <= 1'b0;
            r_ret_pc   <= '0;
            r_idx      <= '0;
            r_int_push <= 1'b0;
            r_pc_load  <= 1'b0;
            r_stall    <= 1'b0;
            r_vector   <= '0;
            r_ack      <= '0;
        end else begin
            r_irq_q   <= bus.irq;
            r_pending <= (r_pending & ~w_clr) | w_edge;

            // Taking an interrupt disables nesting from the very next cycle.
            if ((r_state == ST_VECTOR) || w_take || bus.di) begin
                r_gie <= 1'b0;
            end else if (bus.ei || w_reti_ok) begin
                r_gie <= 1'b1;
            end

            if (w_push_err || w_pop_err) begin
                r_err <= 1'b1;
            end

            if (w_cpu_push_ok) begin
                r_frame[r_depth[DW-1:0]] <= 1'b0;
                r_depth                  <= r_depth + 5'd1;
            end else if (w_cpu_pop_ok) begin
                r_depth <= r_depth - 5'd1;
            end else if (r_state == ST_PUSH) begin
                r_frame[r_depth[DW-1:0]] <= 1'b1;
                r_depth                  <= r_depth + 5'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_pc_load <= 1'b0;
                    r_ack     <= '0;
                    r_vector  <= '0;
                    if (w_take) begin
                        r_ret_pc   <= bus.next_pc;
                        r_idx      <= w_idx;
                        r_int_push <= 1'b1;
                        r_stall    <= 1'b1;
                        r_state    <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    r_int_push <= 1'b0;
                    r_pc_load  <= 1'b1;
                    r_ack      <= N_IRQ'(1) << r_idx;
                    r_vector   <= c_vec_base + AW'(r_idx) * c_vec_stride;
                    r_state    <= ST_VECTOR;
                end
                ST_VECTOR: begin
                    r_pc_load <= 1'b0;
                    r_ack     <= '0;
                    r_vector  <= '0;
                    r_stall   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_int_push <= 1'b0;
                    r_pc_load  <= 1'b0;
                    r_ack      <= '0;
                    r_vector   <= '0;
                    r_stall    <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are masked during reset so an aborted entry emits nothing.
    assign bus.stk_push  = ~reset & (w_cpu_push_ok | r_int_push);
    assign bus.stk_pop   = ~reset & w_cpu_pop_ok;
    assign bus.stk_din   = (r_state == ST_PUSH) ? r_ret_pc : bus.cpu_din;
    assign bus.stk_intr  = w_stk_intr;
    assign bus.pc_load   = ~reset & r_pc_load;
    assign bus.vector    = reset ? '0 : r_vector;
    assign bus.irq_ack   = reset ? '0 : r_ack;
    assign bus.cpu_stall = ~reset & r_stall;
    assign bus.gie       = r_gie;
    assign bus.depth     = r_depth;
    assign bus.stk_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_intr_stack_ctrl.sv
// ============================================================================
//  Module      : tb_intr_stack_ctrl
//  Description : Scoreboard bench for intr_stack_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intr_stack_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    logic [9:0]  q_push[$];
    logic [13:0] q_vec[$];
    logic        q_pop[$];

    intr_stack_if bus ();

    intr_stack_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [9:0] pc, input int idx);
        q_push.push_back(pc);
        q_vec.push_back({10'h3E0 + 10'(idx * 4), 4'(1 << idx)});
    endtask

    task automatic do_pop(input logic is_reti, input logic exp_intr);
        q_pop.push_back(exp_intr);
        bus.cpu_pop = 1'b1;
        bus.reti    = is_reti;
        cyc();
        bus.cpu_pop = 1'b0;
        bus.reti    = 1'b0;
    endtask

    task automatic instr_end_pulse(input logic [9:0] pc);
        bus.instr_end = 1'b1;
        bus.next_pc   = pc;
        cyc();
        bus.instr_end = 1'b0;
    endtask

    // Scoreboard: every stack/vector event the DUT produces is matched in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.stk_push) begin
                if (q_push.size() == 0) check_eq("push_unexpected", 32'(bus.stk_din), 32'hFFFF);
                else check_eq("stk_din", 32'(bus.stk_din), 32'(q_push.pop_front()));
            end
            if (bus.pc_load) begin
                if (q_vec.size() == 0) check_eq("pc_load_unexpected", 32'(bus.vector), 32'hFFFF);
                else check_eq("vector_ack", 32'({bus.vector, bus.irq_ack}), 32'(q_vec.pop_front()));
            end
            if (bus.stk_pop) begin
                if (q_pop.size() == 0) check_eq("pop_unexpected", 32'(bus.stk_intr), 32'hFFFF);
                else check_eq("stk_intr_on_pop", 32'(bus.stk_intr), 32'(q_pop.pop_front()));
            end
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        bus.irq = '0;
        bus.irq_mask = 4'b1111;
        bus.ei = 1'b0;
        bus.di = 1'b0;
        bus.instr_end = 1'b0;
        bus.next_pc = '0;
        bus.cpu_push = 1'b0;
        bus.cpu_din = '0;
        bus.cpu_pop = 1'b0;
        bus.reti = 1'b0;

        // T1 reset
        cyc();
        cyc();
        @(negedge clk);
        check_eq("rst_outputs", 32'({bus.stk_push, bus.stk_pop, bus.pc_load, bus.cpu_stall,
                                     bus.stk_intr, bus.stk_err, bus.gie}), 32'd0);
        check_eq("rst_vector", 32'(bus.vector), 32'd0);
        check_eq("rst_ack", 32'(bus.irq_ack), 32'd0);
        check_eq("rst_depth", 32'(bus.depth), 32'd0);
        cyc();
        reset = 1'b0;

        // T2 interrupt entry
        bus.ei = 1'b1;
        cyc();
        bus.ei = 1'b0;
        check_eq("gie_after_ei", 32'(bus.gie), 32'd1);
        bus.irq = 4'b0100;
        cyc();
        expect_entry(10'h045, 2);
        instr_end_pulse(10'h045);
        check_eq("t2_push_strobe", 32'({bus.stk_push, bus.cpu_stall}), 32'b11);
        cyc();
        check_eq("t2_pc_load", 32'({bus.pc_load, bus.cpu_stall}), 32'b11);
        check_eq("t2_gie", 32'(bus.gie), 32'd0);
        check_eq("t2_depth", 32'(bus.depth), 32'd1);
        cyc();
        check_eq("t2_stall_release", 32'({bus.cpu_stall, bus.pc_load}), 32'd0);

        // T3 RETI
        #1;
        check_eq("t3_top_is_intr", 32'(bus.stk_intr), 32'd1);
        do_pop(1'b1, 1'b1);
        check_eq("t3_gie", 32'(bus.gie), 32'd1);
        check_eq("t3_depth", 32'(bus.depth), 32'd0);

        // T4 priority
        bus.irq = 4'b0000;
        cyc();
        bus.irq = 4'b1000;
        cyc();
        bus.irq = 4'b1010;
        cyc();
        expect_entry(10'h100, 1);
        instr_end_pulse(10'h100);
        cyc();
        cyc();
        check_eq("t4_gie_off", 32'(bus.gie), 32'd0);
        do_pop(1'b1, 1'b1);
        expect_entry(10'h123, 3);
        instr_end_pulse(10'h123);
        cyc();
        cyc();
        do_pop(1'b1, 1'b1);
        check_eq("t4_depth", 32'(bus.depth), 32'd0);

        // T5 CPU push wins over a simultaneous interrupt point
        bus.irq = 4'b0000;
        cyc();
        bus.irq = 4'b0001;
        cyc();
        q_push.push_back(10'h0AA);
        bus.cpu_push = 1'b1;
        bus.cpu_din = 10'h0AA;
        instr_end_pulse(10'h050);
        bus.cpu_push = 1'b0;
        check_eq("t5_no_stall", 32'(bus.cpu_stall), 32'd0);
        check_eq("t5_call_frame", 32'({bus.depth, bus.stk_intr}), 32'({5'd1, 1'b0}));
        expect_entry(10'h051, 0);
        instr_end_pulse(10'h051);
        cyc();
        cyc();
        check_eq("t5_intr_frame", 32'({bus.depth, bus.stk_intr}), 32'({5'd2, 1'b1}));
        do_pop(1'b1, 1'b1);
        do_pop(1'b0, 1'b0);
        check_eq("t5_ret_keeps_gie", 32'(bus.gie), 32'd1);

        // T6 overflow / pending retention / underflow
        bus.irq = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            q_push.push_back(10'(i + 'h10));
            bus.cpu_push = 1'b1;
            bus.cpu_din = 10'(i + 'h10);
            cyc();
        end
        bus.cpu_push = 1'b0;
        check_eq("t6_full", 32'({bus.depth, bus.stk_err}), 32'({5'd16, 1'b0}));
        bus.cpu_push = 1'b1;
        bus.cpu_din = 10'h3FF;
        bus.irq = 4'b0001;
        #1;
        check_eq("t6_push_suppressed", 32'(bus.stk_push), 32'd0);
        cyc();
        bus.cpu_push = 1'b0;
        check_eq("t6_overflow", 32'({bus.depth, bus.stk_err}), 32'({5'd16, 1'b1}));
        instr_end_pulse(10'h200);
        check_eq("t6_no_entry", 32'(bus.cpu_stall), 32'd0);
        cyc();
        cyc();
        check_eq("t6_depth_held", 32'(bus.depth), 32'd16);
        do_pop(1'b0, 1'b0);
        expect_entry(10'h201, 0);
        instr_end_pulse(10'h201);
        cyc();
        cyc();
        check_eq("t6_pending_served", 32'(bus.depth), 32'd16);
        do_pop(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) do_pop(1'b0, 1'b0);
        check_eq("t6_drained", 32'(bus.depth), 32'd0);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("t6_err_cleared", 32'(bus.stk_err), 32'd0);
        bus.cpu_pop = 1'b1;
        #1;
        check_eq("t6_pop_suppressed", 32'(bus.stk_pop), 32'd0);
        cyc();
        bus.cpu_pop = 1'b0;
        check_eq("t6_underflow", 32'({bus.depth, bus.stk_err}), 32'({5'd0, 1'b1}));

        // Reset during PUSH aborts the entry
        bus.irq = 4'b0000;
        bus.ei = 1'b1;
        cyc();
        bus.ei = 1'b0;
        bus.irq = 4'b0010;
        cyc();
        instr_end_pulse(10'h300);
        reset = 1'b1;
        #1;
        check_eq("abort_no_strobe", 32'({bus.stk_push, bus.cpu_stall}), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        check_eq("abort_state", 32'({bus.depth, bus.pc_load, bus.gie}), 32'd0);

        check_eq("q_push_empty", 32'(q_push.size()), 32'd0);
        check_eq("q_vec_empty", 32'(q_vec.size()), 32'd0);
        check_eq("q_pop_empty", 32'(q_pop.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
